// File: rtl/mrt_pkg.sv
// Shared definitions for the MinRoot datapath.
//   MulLatency  : issue-to-product latency of the field multiplier, in cycles.
//   seq_state_e : state encoding of the square-and-multiply sequencer.
package mrt_pkg;

    localparam int unsigned MulLatency = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLoadX,
        StInit,
        StSqIssue,
        StSqWait,
        StMulIssue,
        StMulWait,
        StDone
    } seq_state_e;

endpackage

// File: rtl/msb_find.sv
// Leading-one detector.
//   vec_i  : input vector.
//   idx_o  : index of the most significant set bit (0 when vec_i is zero).
//   zero_o : high when vec_i has no bit set.
module msb_find #(
    parameter int unsigned Width = 256,
    parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] vec_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             zero_o
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        idx_o = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            if (vec_i[i]) begin
                idx_o = IdxW'(i);
            end
        end
    end

    assign zero_o = ~|vec_i;

endmodule

// File: rtl/poly_red_seq.sv
// Square-and-multiply sequencer driving the poly_red reduction stage.
// Computes x^e left to right: loads the base into byp, seeds mul with x, then for each
// lower exponent bit squares mul and, if the bit is set, multiplies mul by byp.
//   clk_i, rst_ni    : clock, asynchronous active-low reset.
//   start_i, exp_i   : start request and exponent (sampled in IDLE only).
//   abort_i          : synchronous abort of a running sequence.
//   busy_o, done_o   : sequence active / one-cycle completion pulse.
//   err_o            : qualifies done_o, exponent was zero.
//   mul_start_o      : multiplier issue strobe.
//   mul_opsel_o      : 0 = mul*mul, 1 = mul*byp.
//   sel_x_o, sel_mul_o, adv_mul_o, adv_byp_o : poly_red control pins.
module poly_red_seq #(
    parameter int unsigned ExpBits    = 256,
    parameter int unsigned MulLatency = mrt_pkg::MulLatency
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [ExpBits-1:0] exp_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               mul_start_o,
    output logic               mul_opsel_o,
    output logic               sel_x_o,
    output logic               sel_mul_o,
    output logic               adv_mul_o,
    output logic               adv_byp_o
);

    import mrt_pkg::*;

    localparam int unsigned IdxW = (ExpBits > 1) ? $clog2(ExpBits) : 1;
    localparam int unsigned CntW = (MulLatency > 1) ? $clog2(MulLatency) : 1;

    seq_state_e         state_q, state_d;
    logic [ExpBits-1:0] exp_q, exp_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic mul_start_q, mul_start_d;
    logic mul_opsel_q, mul_opsel_d;
    logic sel_x_q, sel_x_d;
    logic sel_mul_q, sel_mul_d;
    logic adv_mul_q, adv_mul_d;
    logic adv_byp_q, adv_byp_d;

    logic [IdxW-1:0] msb_idx;
    logic            exp_zero;
    logic            capture_d;

    msb_find #(
        .Width (ExpBits),
        .IdxW  (IdxW)
    ) u_msb_find (
        .vec_i  (exp_i),
        .idx_o  (msb_idx),
        .zero_o (exp_zero)
    );

    // Next-state logic. idx_q holds m right after start, then the current bit index.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    exp_d   = exp_i;
                    idx_d   = msb_idx;
                    state_d = exp_zero ? StDone : StLoadX;
                end
            end
            StLoadX: state_d = StInit;
            StInit: begin
                if (idx_q == '0) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = StSqIssue;
                end
            end
            StSqIssue: begin
                cnt_d   = CntW'(MulLatency - 1);
                state_d = StSqWait;
            end
            StSqWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (exp_q[idx_q]) begin
                    state_d = StMulIssue;
                end else if (idx_q == '0) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = StSqIssue;
                end
            end
            StMulIssue: begin
                cnt_d   = CntW'(MulLatency - 1);
                state_d = StMulWait;
            end
            StMulWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (idx_q == '0) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = StSqIssue;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q after the edge.
    always_comb begin
        capture_d   = ((state_d == StSqWait) || (state_d == StMulWait)) && (cnt_d == '0);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        err_d       = (state_q == StIdle) && (state_d == StDone);
        mul_start_d = (state_d == StSqIssue) || (state_d == StMulIssue);
        mul_opsel_d = (state_d == StMulIssue) || (state_d == StMulWait);
        sel_x_d     = (state_d == StLoadX);
        adv_byp_d   = (state_d == StLoadX);
        sel_mul_d   = capture_d;
        adv_mul_d   = capture_d || (state_d == StInit);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            exp_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mul_start_q <= 1'b0;
            mul_opsel_q <= 1'b0;
            sel_x_q     <= 1'b0;
            sel_mul_q   <= 1'b0;
            adv_mul_q   <= 1'b0;
            adv_byp_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mul_start_q <= mul_start_d;
            mul_opsel_q <= mul_opsel_d;
            sel_x_q     <= sel_x_d;
            sel_mul_q   <= sel_mul_d;
            adv_mul_q   <= adv_mul_d;
            adv_byp_q   <= adv_byp_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign mul_start_o = mul_start_q;
    assign mul_opsel_o = mul_opsel_q;
    assign sel_x_o     = sel_x_q;
    assign sel_mul_o   = sel_mul_q;
    assign adv_byp_o   = adv_byp_q;
    // An abort arriving in a capture cycle must keep the accumulator untouched, so the
    // already-registered strobe is squashed combinationally.
    assign adv_mul_o   = adv_mul_q & ~abort_i;

endmodule

// File: tb/tb_poly_red_seq.sv
// Scoreboard bench for poly_red_seq: expected control events are generated from the
// exponent bits and pushed to a queue; a monitor pops and compares on every strobe.
// A small modular datapath model driven by the DUT controls checks the final x^e.
module tb_poly_red_seq;

    localparam int          EB = 256;
    localparam int unsigned L  = 3;
    localparam longint      P  = 1000003;

    // Vector bit order: busy done err mul_start opsel sel_x sel_mul adv_mul adv_byp
    localparam logic [8:0] V_LOADX = 9'b100001001;
    localparam logic [8:0] V_INIT  = 9'b100000010;
    localparam logic [8:0] V_SQI   = 9'b100100000;
    localparam logic [8:0] V_MULI  = 9'b100110000;
    localparam logic [8:0] V_SQC   = 9'b100000110;
    localparam logic [8:0] V_MULC  = 9'b100010110;
    localparam logic [8:0] V_DONE  = 9'b110000000;
    localparam logic [8:0] V_ERR   = 9'b111000000;
    localparam logic [8:0] V_ABRT  = 9'b100000100;
    localparam logic [8:0] M_ALL   = 9'h1FF;
    localparam logic [8:0] M_ABRT  = 9'h1FB;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [EB-1:0] exp_i = '0;
    logic busy_o, done_o, err_o, mul_start_o, mul_opsel_o;
    logic sel_x_o, sel_mul_o, adv_mul_o, adv_byp_o;
    logic [8:0] outv;

    assign outv = {busy_o, done_o, err_o, mul_start_o, mul_opsel_o,
                   sel_x_o, sel_mul_o, adv_mul_o, adv_byp_o};

    poly_red_seq #(
        .ExpBits    (EB),
        .MulLatency (L)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .exp_i       (exp_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .mul_start_o (mul_start_o),
        .mul_opsel_o (mul_opsel_o),
        .sel_x_o     (sel_x_o),
        .sel_mul_o   (sel_mul_o),
        .adv_mul_o   (adv_mul_o),
        .adv_byp_o   (adv_byp_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [8:0] vec;
        logic [8:0] mask;
        bit         chk_acc;
        longint     acc;
    } ev_t;

    ev_t    sb[$];
    int     checks = 0;
    int     failures = 0;
    longint x_cur = 1;
    longint byp_m = 0;
    longint acc_m = 0;
    longint pend_m = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic void push_ev(int c, logic [8:0] v, logic [8:0] m, bit ca, longint a);
        ev_t e;
        e.cyc = c; e.vec = v; e.mask = m; e.chk_acc = ca; e.acc = a;
        sb.push_back(e);
    endfunction

    function automatic longint pow_mod(longint x, int unsigned e);
        longint r = 1;
        for (int unsigned k = 0; k < e; k++) r = (r * x) % P;
        return r;
    endfunction

    // Expected event trace for exponent e started at cycle s; returns the done cycle.
    function automatic int build(logic [EB-1:0] e, int s, longint x, bit chk);
        int            m = -1;
        int            t;
        logic [15:0]   e_lo;
        longint        a = 0;
        for (int i = 0; i < EB; i++) if (e[i]) m = i;
        if (m < 0) begin
            push_ev(s + 1, V_ERR, M_ALL, 1'b0, 0);
            return s + 1;
        end
        push_ev(s + 1, V_LOADX, M_ALL, 1'b0, 0);
        push_ev(s + 2, V_INIT, M_ALL, 1'b0, 0);
        t = s + 3;
        for (int i = m - 1; i >= 0; i--) begin
            push_ev(t, V_SQI, M_ALL, 1'b0, 0);
            push_ev(t + int'(L), V_SQC, M_ALL, 1'b0, 0);
            t += int'(L) + 1;
            if (e[i]) begin
                push_ev(t, V_MULI, M_ALL, 1'b0, 0);
                push_ev(t + int'(L), V_MULC, M_ALL, 1'b0, 0);
                t += int'(L) + 1;
            end
        end
        if (chk) begin
            e_lo = e[15:0];
            a = pow_mod(x, int'(e_lo));
        end
        push_ev(t, V_DONE, M_ALL, chk, a);
        return t;
    endfunction

    // Behavioural stand-in for multiplier + poly_red registers.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (sel_x_o && adv_byp_o) byp_m = x_cur;
            if (adv_mul_o) acc_m = sel_mul_o ? pend_m : x_cur;
            if (mul_start_o) pend_m = mul_opsel_o ? (acc_m * byp_m) % P : (acc_m * acc_m) % P;
        end
    end

    // Monitor: compare on every strobe and on every cycle an event is due.
    always @(negedge clk) begin
        ev_t ev;
        if (rst_ni) begin
            while (sb.size() != 0 && sb[0].cyc < cyc) begin
                ev = sb.pop_front();
                check("missed_event_cycle", cyc, ev.cyc);
            end
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                ev = sb.pop_front();
                check("event_vector", outv & ev.mask, ev.vec & ev.mask);
                if (ev.chk_acc) check("final_mul_value", acc_m, ev.acc);
            end else if (done_o | mul_start_o | sel_x_o | sel_mul_o | adv_mul_o | adv_byp_o) begin
                check("unexpected_strobe", outv, 0);
            end
        end
    end

    task automatic run(input logic [EB-1:0] e, input longint x, input bit chk,
                       input int abort_off, input int reset_off, input int busy_off);
        int s, done_c, end_c;
        @(posedge clk); #1;
        x_cur   = x;
        exp_i   = e;
        start_i = 1'b1;
        abort_i = 1'($urandom_range(0, 1));  // abort in IDLE must not block the start
        s       = cyc;
        done_c  = build(e, s, x, chk);
        if (abort_off >= 0) begin
            while (sb.size() != 0 && sb[$].cyc >= s + abort_off) void'(sb.pop_back());
            push_ev(s + abort_off, V_ABRT, M_ABRT, 1'b0, 0);
            end_c = s + abort_off + 1;
        end else if (reset_off >= 0) begin
            end_c = s + reset_off;
        end else begin
            end_c = done_c + 1;
        end
        for (int c = s + 1; c <= end_c; c++) begin
            @(posedge clk); #1;
            start_i = (busy_off >= 0) && (c == s + busy_off);
            if (start_i) exp_i = EB'($urandom) | EB'(1);
            abort_i = (abort_off >= 0) && (c == s + abort_off);
            if (abort_off >= 0 && c == s + abort_off + 1) begin
                check("abort_busy_next", busy_o, 0);
                check("abort_outputs_next", outv, 0);
            end
            if (reset_off >= 0 && c == s + reset_off) begin
                #1 rst_ni = 1'b0;
                #1 check("reset_mid_seq_outputs", outv, 0);
                while (sb.size() != 0 && sb[$].cyc >= s + reset_off) void'(sb.pop_back());
                @(negedge clk); #1 rst_ni = 1'b1;
            end
        end
        if (abort_off < 0 && reset_off < 0) check("idle_after_done", busy_o, 0);
        start_i = 1'b0;
        abort_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [EB-1:0] e;
        #3 check("reset_outputs", outv, 0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk); #1 check("idle_outputs", outv, 0);

        run(EB'(1), 7, 1'b1, -1, -1, -1);
        run(EB'(5), 12345, 1'b1, -1, -1, -1);
        run(EB'(0), 99, 1'b0, -1, -1, -1);
        run(EB'(8'hFF), 777, 1'b1, -1, -1, 20);
        run(EB'(5), 4242, 1'b0, 10, -1, -1);
        run(EB'(5), 31337, 1'b1, -1, -1, -1);
        run(EB'(5), 555, 1'b0, -1, 12, -1);
        run(EB'(5), 2024, 1'b1, -1, -1, -1);
        e = '0;
        e[EB-1] = 1'b1;
        run(e, 3, 1'b0, -1, -1, -1);
        for (int n = 0; n < 12; n++) begin
            e = EB'($urandom_range(0, 4095));
            run(e, longint'($urandom_range(2, 1000000)), e != '0, -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
